// File: rtl/exu_ctrl.sv
// exu_ctrl: multicycle sequencing and decode controller for an RV32I core.
//
// Accepts one instruction at a time from fetch, decodes it, drives the ALU
// opcode and operand selects, then sequences data-memory access and the
// register-file / PC writeback before accepting the next instruction.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   inst_valid, inst     instruction offered by fetch
//   inst_ready           high only while waiting for an instruction
//   alu_res              ALU result (combinational from current selects)
//   aluop, sel_a, sel_b  ALU opcode and operand selects
//   imm                  sign-extended immediate of the latched instruction
//   rs1/rs2/rd_addr      register fields of the latched instruction
//   res_we               datapath latches alu_res into its result register
//   mem_req/we/size      data-memory request, held until mem_ack
//   mem_ack              memory completes the request
//   rf_we, wb_sel        register-file write and its data source
//   pc_we, pc_sel        PC write and its source
//   halt, illegal        sticky ebreak / illegal-instruction indications
//
// Control outputs are registered: the next-state logic also decodes the
// outputs belonging to the next state, so every control output is a flop.
module exu_ctrl #(
    parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    output logic        inst_ready,
    input  logic [31:0] alu_res,
    output logic [3:0]  aluop,
    output logic [1:0]  sel_a,
    output logic [1:0]  sel_b,
    output logic [31:0] imm,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic        res_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_size,
    input  logic        mem_ack,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        halt,
    output logic        illegal
);

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StBrt, StMem, StWb, StHalt, StTrap
    } state_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcFence  = 7'b0001111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluXor  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluAnd  = 4'd4;
    localparam logic [3:0] AluSlt  = 4'd5;
    localparam logic [3:0] AluSll  = 4'd6;
    localparam logic [3:0] AluSrl  = 4'd7;
    localparam logic [3:0] AluSra  = 4'd8;
    localparam logic [3:0] AluSltu = 4'd9;
    localparam logic [3:0] AluEq   = 4'd10;

    localparam logic [1:0] SelARs1  = 2'd0;
    localparam logic [1:0] SelAPc   = 2'd1;
    localparam logic [1:0] SelAZero = 2'd2;
    localparam logic [1:0] SelBRs2  = 2'd0;
    localparam logic [1:0] SelBImm  = 2'd1;

    localparam logic [1:0] WbRes = 2'd0;
    localparam logic [1:0] WbMem = 2'd1;
    localparam logic [1:0] WbPc4 = 2'd2;

    localparam logic [1:0] PcPlus4  = 2'd0;
    localparam logic [1:0] PcRes    = 2'd1;
    localparam logic [1:0] PcResAln = 2'd2;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        taken_q, taken_d;

    logic        inst_ready_q, inst_ready_d;
    logic [3:0]  aluop_q, aluop_d;
    logic [1:0]  sel_a_q, sel_a_d;
    logic [1:0]  sel_b_q, sel_b_d;
    logic        res_we_q, res_we_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [2:0]  mem_size_q, mem_size_d;
    logic        rf_we_q, rf_we_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic        pc_we_q, pc_we_d;
    logic [1:0]  pc_sel_q, pc_sel_d;
    logic        halt_q, halt_d;
    logic        illegal_q, illegal_d;

    // ------------------------------------------------------------------
    // Decode of the latched instruction
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    logic is_op, is_opimm, is_lui, is_auipc, is_jal, is_jalr;
    logic is_branch, is_load, is_store;

    assign is_op     = (opcode == OpcOp);
    assign is_opimm  = (opcode == OpcOpImm);
    assign is_lui    = (opcode == OpcLui);
    assign is_auipc  = (opcode == OpcAuipc);
    assign is_jal    = (opcode == OpcJal);
    assign is_jalr   = (opcode == OpcJalr);
    assign is_branch = (opcode == OpcBranch);
    assign is_load   = (opcode == OpcLoad);
    assign is_store  = (opcode == OpcStore);

    logic dec_ebreak;
    logic dec_illegal;

    assign dec_ebreak = (ir_q == 32'h0010_0073);

    always_comb begin
        dec_illegal = 1'b0;
        case (opcode)
            OpcOp: begin
                dec_illegal = !((funct7 == 7'h00) ||
                                ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
            end
            OpcOpImm: begin
                if (funct3 == 3'd1) begin
                    dec_illegal = (funct7 != 7'h00);
                end else if (funct3 == 3'd5) begin
                    dec_illegal = !((funct7 == 7'h00) || (funct7 == 7'h20));
                end
            end
            OpcLoad:   dec_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            OpcStore:  dec_illegal = (funct3 > 3'd2);
            OpcBranch: dec_illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
            OpcSystem: dec_illegal = !dec_ebreak;
            OpcLui, OpcAuipc, OpcJal, OpcJalr, OpcFence: dec_illegal = 1'b0;
            default:   dec_illegal = 1'b1;
        endcase
    end

    // Register-register / register-immediate ALU op from funct3 plus the
    // alternate-encoding bit (SUB / SRA).
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    arith_op = alt ? AluSub : AluAdd;
            3'd1:    arith_op = AluSll;
            3'd2:    arith_op = AluSlt;
            3'd3:    arith_op = AluSltu;
            3'd4:    arith_op = AluXor;
            3'd5:    arith_op = alt ? AluSra : AluSrl;
            3'd6:    arith_op = AluOr;
            default: arith_op = AluAnd;
        endcase
    endfunction

    logic [3:0] exe_aluop;
    logic [1:0] exe_sel_a;
    logic [1:0] exe_sel_b;
    logic       exe_res_we;
    logic       br_inv;

    always_comb begin
        exe_aluop  = AluAdd;
        exe_sel_a  = SelARs1;
        exe_sel_b  = SelBRs2;
        exe_res_we = is_op | is_opimm | is_lui | is_auipc | is_jal | is_jalr |
                     is_load | is_store;
        // bne/bge/bgeu are the odd funct3 encodings and invert the compare.
        br_inv     = funct3[0];
        if (is_op) begin
            exe_aluop = arith_op(funct3, ir_q[30]);
        end else if (is_opimm) begin
            // Only the right shift has an alternate form among immediates.
            exe_aluop = arith_op(funct3, (funct3 == 3'd5) & ir_q[30]);
            exe_sel_b = SelBImm;
        end else if (is_lui) begin
            exe_sel_a = SelAZero;
            exe_sel_b = SelBImm;
        end else if (is_auipc || is_jal) begin
            exe_sel_a = SelAPc;
            exe_sel_b = SelBImm;
        end else if (is_jalr || is_load || is_store) begin
            exe_sel_b = SelBImm;
        end else if (is_branch) begin
            case (funct3[2:1])
                2'b10:   exe_aluop = AluSlt;
                2'b11:   exe_aluop = AluSltu;
                default: exe_aluop = AluEq;
            endcase
        end
    end

    // Immediate of the latched instruction by format.
    always_comb begin
        imm = 32'd0;
        if (is_opimm || is_jalr || is_load) begin
            imm = {{20{ir_q[31]}}, ir_q[31:20]};
        end else if (is_store) begin
            imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        end else if (is_branch) begin
            imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        end else if (is_lui || is_auipc) begin
            imm = {ir_q[31:12], 12'd0};
        end else if (is_jal) begin
            imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
        end
    end

    assign rs1_addr = ir_q[19:15];
    assign rs2_addr = ir_q[24:20];
    assign rd_addr  = ir_q[11:7];

    // Only the compare bit of the ALU result is consumed here.
    logic unused_alu_res;
    assign unused_alu_res = ^alu_res[31:1];

    // ------------------------------------------------------------------
    // Next state, then the outputs that belong to that next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        taken_d = taken_q;

        unique case (state_q)
            StFetch: begin
                if (inst_valid) begin
                    ir_d    = inst;
                    taken_d = 1'b0;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_illegal) begin
                    state_d = StTrap;
                end else if (dec_ebreak) begin
                    state_d = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_branch) begin
                    taken_d = alu_res[0] ^ br_inv;
                    state_d = taken_d ? StBrt : StWb;
                end else if (is_load || is_store) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StBrt:   state_d = StWb;
            StMem:   state_d = mem_ack ? StWb : StMem;
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            StTrap:  state_d = StTrap;
        endcase

        // Outputs decoded for state_d. Whenever state_d is past DECODE the
        // instruction register is unchanged, so decoding ir_q is exact.
        inst_ready_d = 1'b0;
        aluop_d      = AluAdd;
        sel_a_d      = SelARs1;
        sel_b_d      = SelBRs2;
        res_we_d     = 1'b0;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_size_d   = 3'd0;
        rf_we_d      = 1'b0;
        wb_sel_d     = WbRes;
        pc_we_d      = 1'b0;
        pc_sel_d     = PcPlus4;
        halt_d       = 1'b0;
        illegal_d    = 1'b0;

        unique case (state_d)
            StFetch: begin
                inst_ready_d = 1'b1;
                pc_sel_d     = RESET_PC_SEL;
            end
            StDecode: ;
            StExec: begin
                aluop_d  = exe_aluop;
                sel_a_d  = exe_sel_a;
                sel_b_d  = exe_sel_b;
                res_we_d = exe_res_we;
            end
            StBrt: begin
                sel_a_d  = SelAPc;
                sel_b_d  = SelBImm;
                res_we_d = 1'b1;
            end
            StMem: begin
                mem_req_d  = 1'b1;
                mem_we_d   = is_store;
                mem_size_d = funct3;
            end
            StWb: begin
                pc_we_d = 1'b1;
                if (is_jal || (is_branch && taken_d)) begin
                    pc_sel_d = PcRes;
                end else if (is_jalr) begin
                    pc_sel_d = PcResAln;
                end
                if (is_load) begin
                    wb_sel_d = WbMem;
                end else if (is_jal || is_jalr) begin
                    wb_sel_d = WbPc4;
                end
                rf_we_d = (is_op || is_opimm || is_lui || is_auipc || is_load ||
                           is_jal || is_jalr) && (rd_addr != 5'd0);
            end
            StHalt:  halt_d    = 1'b1;
            StTrap:  illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFetch;
            ir_q         <= 32'd0;
            taken_q      <= 1'b0;
            inst_ready_q <= 1'b1;
            aluop_q      <= AluAdd;
            sel_a_q      <= SelARs1;
            sel_b_q      <= SelBRs2;
            res_we_q     <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_size_q   <= 3'd0;
            rf_we_q      <= 1'b0;
            wb_sel_q     <= WbRes;
            pc_we_q      <= 1'b0;
            pc_sel_q     <= RESET_PC_SEL;
            halt_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            taken_q      <= taken_d;
            inst_ready_q <= inst_ready_d;
            aluop_q      <= aluop_d;
            sel_a_q      <= sel_a_d;
            sel_b_q      <= sel_b_d;
            res_we_q     <= res_we_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_size_q   <= mem_size_d;
            rf_we_q      <= rf_we_d;
            wb_sel_q     <= wb_sel_d;
            pc_we_q      <= pc_we_d;
            pc_sel_q     <= pc_sel_d;
            halt_q       <= halt_d;
            illegal_q    <= illegal_d;
        end
    end

    assign inst_ready = inst_ready_q;
    assign aluop      = aluop_q;
    assign sel_a      = sel_a_q;
    assign sel_b      = sel_b_q;
    assign res_we     = res_we_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_size   = mem_size_q;
    assign rf_we      = rf_we_q;
    assign wb_sel     = wb_sel_q;
    assign pc_we      = pc_we_q;
    assign pc_sel     = pc_sel_q;
    assign halt       = halt_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_exu_ctrl.sv
// Directed self-checking bench for exu_ctrl.
module tb_exu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic [31:0] alu_res;
    logic [3:0]  aluop;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        res_we;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        mem_ack;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        halt;
    logic        illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    exu_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_ready (inst_ready),
        .alu_res    (alu_res),
        .aluop      (aluop),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .imm        (imm),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd_addr    (rd_addr),
        .res_we     (res_we),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_size   (mem_size),
        .mem_ack    (mem_ack),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .halt       (halt),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Every output in one vector: after reset only inst_ready is set.
    logic [69:0] outs;
    assign outs = {inst_ready, aluop, sel_a, sel_b, imm, rs1_addr, rs2_addr, rd_addr, res_we,
                   mem_req, mem_we, mem_size, rf_we, wb_sel, pc_we, pc_sel, halt, illegal};
    localparam logic [69:0] RstOuts = {1'b1, 69'd0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        step();
    endtask

    // Handshake one instruction; returns in DECODE with inst scrambled so
    // decode must come from the latched copy.
    task automatic issue(input logic [31:0] word);
        n_cmp++;
        if (inst_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready got %b want 1", inst_ready);
        end
        inst_valid = 1'b1;
        inst       = word;
        step();
        inst_valid = 1'b0;
        inst       = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_cmp++;
        if (outs !== RstOuts) begin
            n_fail++;
            $display("FAIL reset_outs got %h want %h", outs, RstOuts);
        end
        do_reset();
        n_cmp++;
        if (outs !== RstOuts) begin
            n_fail++;
            $display("FAIL reset_idle got %h want %h", outs, RstOuts);
        end
    endtask

    // add x3,x1,x2 with mem_ack held high throughout (must be ignored).
    task automatic test_add();
        mem_ack = 1'b1;
        issue(32'h0020_81B3);
        n_cmp++;
        if ({inst_ready, rs1_addr, rs2_addr, rd_addr, res_we} !== {1'b0, 5'd1, 5'd2, 5'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL add_decode got %b/%0d/%0d/%0d/%b want 0/1/2/3/0",
                     inst_ready, rs1_addr, rs2_addr, rd_addr, res_we);
        end
        step();
        alu_res = 32'd5;
        n_cmp++;
        if ({aluop, sel_a, sel_b, res_we, pc_we} !== {4'd0, 2'd0, 2'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_exec got aluop=%0d sa=%0d sb=%0d rwe=%b pwe=%b want 0 0 0 1 0",
                     aluop, sel_a, sel_b, res_we, pc_we);
        end
        step();
        n_cmp++;
        if ({rf_we, rd_addr, wb_sel, pc_we, pc_sel, res_we, mem_req} !==
            {1'b1, 5'd3, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_wb got rfwe=%b rd=%0d wbs=%0d pwe=%b psel=%0d rwe=%b mreq=%b",
                     rf_we, rd_addr, wb_sel, pc_we, pc_sel, res_we, mem_req);
        end
        step();
        n_cmp++;
        if ({inst_ready, pc_we, rf_we} !== 3'b100) begin
            n_fail++;
            $display("FAIL add_refetch got rdy=%b pwe=%b rfwe=%b want 1 0 0", inst_ready, pc_we, rf_we);
        end
        mem_ack = 1'b0;
    endtask

    // Single-cycle-EXEC class: check EXEC selects and the WB write pattern.
    task automatic test_class(input string name, input logic [31:0] word, input logic [3:0] x_op,
                              input logic [1:0] x_sa, input logic [1:0] x_sb,
                              input logic [31:0] x_imm, input logic x_rfwe,
                              input logic [1:0] x_wbs, input logic [1:0] x_psel);
        issue(word);
        step();
        alu_res = 32'd0;
        n_cmp++;
        if ({aluop, sel_a, sel_b, imm, res_we} !== {x_op, x_sa, x_sb, x_imm, 1'b1}) begin
            n_fail++;
            $display("FAIL %s_exec got op=%0d sa=%0d sb=%0d imm=%h rwe=%b want %0d %0d %0d %h 1",
                     name, aluop, sel_a, sel_b, imm, res_we, x_op, x_sa, x_sb, x_imm);
        end
        step();
        n_cmp++;
        if ({rf_we, wb_sel, pc_we, pc_sel} !== {x_rfwe, x_wbs, 1'b1, x_psel}) begin
            n_fail++;
            $display("FAIL %s_wb got rfwe=%b wbs=%0d pwe=%b psel=%0d want %b %0d 1 %0d",
                     name, rf_we, wb_sel, pc_we, pc_sel, x_rfwe, x_wbs, x_psel);
        end
        step();
    endtask

    task automatic test_branch();
        // bne x1,x2,+8 with eq=0: taken.
        issue(32'h0020_9463);
        step();
        alu_res = 32'd0;
        n_cmp++;
        if ({aluop, sel_a, sel_b, res_we} !== {4'd10, 2'd0, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL bne_exec got op=%0d sa=%0d sb=%0d rwe=%b want 10 0 0 0",
                     aluop, sel_a, sel_b, res_we);
        end
        step();
        n_cmp++;
        if ({aluop, sel_a, sel_b, imm, res_we, pc_we} !== {4'd0, 2'd1, 2'd1, 32'd8, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL bne_brt got op=%0d sa=%0d sb=%0d imm=%h rwe=%b pwe=%b",
                     aluop, sel_a, sel_b, imm, res_we, pc_we);
        end
        step();
        n_cmp++;
        if ({pc_we, pc_sel, rf_we, res_we} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bne_taken_wb got pwe=%b psel=%0d rfwe=%b rwe=%b want 1 1 0 0",
                     pc_we, pc_sel, rf_we, res_we);
        end
        step();
        // Same branch with eq=1: not taken, straight to WB.
        issue(32'h0020_9463);
        step();
        alu_res = 32'd1;
        step();
        n_cmp++;
        if ({pc_we, pc_sel, rf_we, res_we} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bne_not_taken_wb got pwe=%b psel=%0d rfwe=%b rwe=%b want 1 0 0 0",
                     pc_we, pc_sel, rf_we, res_we);
        end
        step();
    endtask

    task automatic test_load();
        issue(32'h0040_A283);  // lw x5,4(x1)
        step();
        n_cmp++;
        if ({aluop, sel_a, sel_b, imm, res_we} !== {4'd0, 2'd0, 2'd1, 32'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL lw_exec got op=%0d sa=%0d sb=%0d imm=%h rwe=%b", aluop, sel_a, sel_b,
                     imm, res_we);
        end
        step();
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if ({mem_req, mem_we, mem_size, pc_we, rf_we} !== {1'b1, 1'b0, 3'd2, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL lw_mem_cycle%0d got req=%b we=%b size=%0d pwe=%b rfwe=%b",
                         c, mem_req, mem_we, mem_size, pc_we, rf_we);
            end
            if (c == 2) mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        n_cmp++;
        if ({mem_req, rf_we, wb_sel, pc_we, pc_sel, rd_addr} !==
            {1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 5'd5}) begin
            n_fail++;
            $display("FAIL lw_wb got req=%b rfwe=%b wbs=%0d pwe=%b psel=%0d rd=%0d",
                     mem_req, rf_we, wb_sel, pc_we, pc_sel, rd_addr);
        end
        step();
    endtask

    task automatic test_store();
        issue(32'h0020_A423);  // sw x2,8(x1)
        step();
        n_cmp++;
        if ({sel_a, sel_b, imm, res_we} !== {2'd0, 2'd1, 32'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL sw_exec got sa=%0d sb=%0d imm=%h rwe=%b", sel_a, sel_b, imm, res_we);
        end
        step();
        n_cmp++;
        if ({mem_req, mem_we, mem_size} !== {1'b1, 1'b1, 3'd2}) begin
            n_fail++;
            $display("FAIL sw_mem got req=%b we=%b size=%0d want 1 1 2", mem_req, mem_we, mem_size);
        end
        mem_ack = 1'b1;  // ack in the first MEM cycle
        step();
        mem_ack = 1'b0;
        n_cmp++;
        if ({mem_req, rf_we, pc_we, pc_sel} !== {1'b0, 1'b0, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL sw_wb got req=%b rfwe=%b pwe=%b psel=%0d want 0 0 1 0",
                     mem_req, rf_we, pc_we, pc_sel);
        end
        step();
    endtask

    task automatic test_absorbing(input string name, input logic [31:0] word,
                                  input logic x_halt, input logic x_ill);
        issue(word);
        step();
        for (int c = 0; c < 3; c++) begin
            inst_valid = 1'b1;
            n_cmp++;
            if ({inst_ready, halt, illegal, pc_we, rf_we, mem_req} !=
                {1'b0, x_halt, x_ill, 3'b000}) begin
                n_fail++;
                $display("FAIL %s_sticky%0d got rdy=%b halt=%b ill=%b pwe=%b rfwe=%b req=%b",
                         name, c, inst_ready, halt, illegal, pc_we, rf_we, mem_req);
            end
            step();
        end
        inst_valid = 1'b0;
        do_reset();
        n_cmp++;
        if (outs !== RstOuts) begin
            n_fail++;
            $display("FAIL %s_rst got %h want %h", name, outs, RstOuts);
        end
    endtask

    task automatic test_reset_mid_mem();
        issue(32'h0040_A283);
        step();
        step();
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL midmem_req got %b want 1", mem_req);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (outs !== RstOuts) begin
            n_fail++;
            $display("FAIL midmem_async got %h want %h", outs, RstOuts);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        mem_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_cmp++;
            if ({rf_we, pc_we, mem_req, inst_ready} !== 4'b0001) begin
                n_fail++;
                $display("FAIL midmem_after%0d got rfwe=%b pwe=%b req=%b rdy=%b want 0 0 0 1",
                         c, rf_we, pc_we, mem_req, inst_ready);
            end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        inst_valid = 1'b0;
        inst       = 32'd0;
        alu_res    = 32'd0;
        mem_ack    = 1'b0;
        test_reset();
        test_add();
        test_class("sub",  32'h4020_81B3, 4'd1, 2'd0, 2'd0, 32'd0,         1'b1, 2'd0, 2'd0);
        test_class("srai", 32'h4030_D213, 4'd8, 2'd0, 2'd1, 32'h0000_0403, 1'b1, 2'd0, 2'd0);
        test_class("lui",  32'h1234_53B7, 4'd0, 2'd2, 2'd1, 32'h1234_5000, 1'b1, 2'd0, 2'd0);
        test_class("jal",  32'h0100_00EF, 4'd0, 2'd1, 2'd1, 32'd16,        1'b1, 2'd2, 2'd1);
        test_class("jalr", 32'h0001_00E7, 4'd0, 2'd0, 2'd1, 32'd0,         1'b1, 2'd2, 2'd2);
        test_class("rd0",  32'h0020_8033, 4'd0, 2'd0, 2'd0, 32'd0,         1'b0, 2'd0, 2'd0);
        test_branch();
        test_load();
        test_store();
        test_absorbing("allones", 32'hFFFF_FFFF, 1'b0, 1'b1);
        test_absorbing("badf7",   32'h4020_91B3, 1'b0, 1'b1);
        test_absorbing("ecall",   32'h0000_0073, 1'b0, 1'b1);
        test_absorbing("ebreak",  32'h0010_0073, 1'b1, 1'b0);
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "timeout");
    end

endmodule
